// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared op encodings, FSM states and default latencies for e_mdu
package mdu_pkg;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;

    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

endpackage

// File: rtl/e_mdu.sv
// rtl/e_mdu.sv - execute-stage multiply/divide unit with HI/LO and busy for stall generation
// Optional MADD/MADDU accumulate support is enabled by defining MDU_MADD_EN.
module e_mdu
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] E_RD1,
    input  logic [31:0] E_RD2,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] mdu_out
);

    mdu_state_e  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [63:0] pend_q, pend_d;
    logic        pend_wr_q, pend_wr_d;

    logic [63:0] prod_s, prod_u;
    logic        div_signed, div_zero;
    logic [31:0] div_b, mag_a, mag_b, q_mag, r_mag, q_res, r_res;
    logic        res_ok, res_wr;
    logic [63:0] res_val;
    logic [3:0]  res_cyc;

    // Low 64 bits of a product of sign-extended operands equal the signed product.
    always_comb begin
        prod_s = {{32{E_RD1[31]}}, E_RD1} * {{32{E_RD2[31]}}, E_RD2};
        prod_u = {32'd0, E_RD1} * {32'd0, E_RD2};
    end

    // One magnitude divider serves both DIV and DIVU; signs are restored afterwards.
    always_comb begin
        div_signed = (op == OP_DIV);
        div_zero   = (E_RD2 == 32'd0);
        div_b      = div_zero ? 32'd1 : E_RD2;
        mag_a      = (div_signed && E_RD1[31]) ? -E_RD1 : E_RD1;
        mag_b      = (div_signed && div_b[31]) ? -div_b : div_b;
        q_mag      = mag_a / mag_b;
        r_mag      = mag_a % mag_b;
        q_res      = (div_signed && (E_RD1[31] ^ div_b[31])) ? -q_mag : q_mag;
        r_res      = (div_signed && E_RD1[31]) ? -r_mag : r_mag;
    end

    always_comb begin
        res_ok  = 1'b0;
        res_wr  = 1'b0;
        res_val = 64'd0;
        res_cyc = 4'd0;
        case (op)
            OP_MULT: begin
                res_ok  = 1'b1;
                res_wr  = 1'b1;
                res_val = prod_s;
                res_cyc = 4'(MULT_CYCLES);
            end
            OP_MULTU: begin
                res_ok  = 1'b1;
                res_wr  = 1'b1;
                res_val = prod_u;
                res_cyc = 4'(MULT_CYCLES);
            end
            OP_DIV, OP_DIVU: begin
                res_ok  = 1'b1;
                res_wr  = !div_zero;
                res_val = {r_res, q_res};
                res_cyc = 4'(DIV_CYCLES);
            end
`ifdef MDU_MADD_EN
            OP_MADD: begin
                res_ok  = 1'b1;
                res_wr  = 1'b1;
                res_val = {hi_q, lo_q} + prod_s;
                res_cyc = 4'(MULT_CYCLES);
            end
            OP_MADDU: begin
                res_ok  = 1'b1;
                res_wr  = 1'b1;
                res_val = {hi_q, lo_q} + prod_u;
                res_cyc = 4'(MULT_CYCLES);
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_d    = pend_q;
        pend_wr_d = pend_wr_q;
        case (state_q)
            ST_IDLE: begin
                if (start && res_ok) begin
                    state_d   = ST_RUN;
                    cnt_d     = res_cyc;
                    pend_d    = res_val;
                    pend_wr_d = res_wr;
                end else if (!start && op == OP_MTHI) begin
                    hi_d = E_RD1;
                end else if (!start && op == OP_MTLO) begin
                    lo_d = E_RD1;
                end
            end
            ST_RUN: begin
                if (cnt_q == 4'd1) begin
                    state_d   = ST_IDLE;
                    cnt_d     = 4'd0;
                    pend_wr_d = 1'b0;
                    if (pend_wr_q) begin
                        hi_d = pend_q[63:32];
                        lo_d = pend_q[31:0];
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_q    <= 64'd0;
            pend_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_q    <= pend_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    always_comb begin
        busy = (state_q == ST_RUN);
        hi   = hi_q;
        lo   = lo_q;
        case (op)
            OP_MFHI: mdu_out = hi_q;
            OP_MFLO: mdu_out = lo_q;
            default: mdu_out = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_e_mdu.sv
// tb/tb_e_mdu.sv - directed self-checking bench for e_mdu
module tb_e_mdu;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] E_RD1;
    logic [31:0] E_RD2;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mdu_out;

    int n_cmp = 0;
    int n_bad = 0;
    int ncyc;

    e_mdu dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .E_RD1   (E_RD1),
        .E_RD2   (E_RD2),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo),
        .mdu_out (mdu_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        E_RD1 = a;
        E_RD2 = b;
        tick();
        start = 1'b0;
        op    = OP_NONE;
    endtask

    task automatic move_to(input logic [3:0] o, input logic [31:0] v);
        op    = o;
        E_RD1 = v;
        tick();
        op    = OP_NONE;
    endtask

    // Counts busy cycles from the current sample until busy drops, bounded.
    task automatic wait_idle(inout int n);
        while (busy && n < 40) begin
            n++;
            tick();
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = OP_NONE;
        E_RD1 = 32'd0;
        E_RD2 = 32'd0;
        tick();
        tick();
        reset = 1'b0;
        op    = OP_MFHI;
        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        check("reset_mfhi", mdu_out, 32'd0);
        op = OP_NONE;

        issue(OP_MULT, 32'hFFFF_FFFD, 32'd7);
        ncyc = 0;
        wait_idle(ncyc);
        check("mult_cycles", ncyc, 32'd5);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFEB);
        op = OP_MFLO;
        #1;
        check("mflo", mdu_out, 32'hFFFF_FFEB);
        op = OP_MFHI;
        #1;
        check("mfhi", mdu_out, 32'hFFFF_FFFF);
        op = OP_NONE;
        #1;
        check("mdu_out_other", mdu_out, 32'd0);

        issue(OP_DIVU, 32'd100, 32'd7);
        ncyc = 0;
        wait_idle(ncyc);
        check("divu_cycles", ncyc, 32'd10);
        check("divu_lo", lo, 32'd14);
        check("divu_hi", hi, 32'd2);

        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        ncyc = 0;
        wait_idle(ncyc);
        check("div_neg_lo", lo, 32'hFFFF_FFFD);
        check("div_neg_hi", hi, 32'hFFFF_FFFF);

        issue(OP_DIV, 32'd7, 32'hFFFF_FFFE);
        ncyc = 0;
        wait_idle(ncyc);
        check("div_negb_lo", lo, 32'hFFFF_FFFD);
        check("div_negb_hi", hi, 32'd1);

        move_to(OP_MTHI, 32'h11);
        move_to(OP_MTLO, 32'h22);
        check("mthi", hi, 32'h11);
        check("mtlo", lo, 32'h22);
        issue(OP_DIV, 32'd5, 32'd0);
        ncyc = 0;
        wait_idle(ncyc);
        check("div0_cycles", ncyc, 32'd10);
        check("div0_hi", hi, 32'h11);
        check("div0_lo", lo, 32'h22);

        issue(OP_MULT, 32'd3, 32'd4);
        ncyc = 1;
        op    = OP_MTHI;
        E_RD1 = 32'h0000_ABCD;
        tick();
        op    = OP_NONE;
        check("mthi_busy_ignored", hi, 32'h11);
        ncyc++;
        tick();
        ncyc++;
        issue(OP_DIVU, 32'd100, 32'd7);
        check("start_busy_busy", {31'd0, busy}, 32'd1);
        check("start_busy_lo", lo, 32'h22);
        wait_idle(ncyc);
        check("busy_op_cycles", ncyc, 32'd5);
        check("busy_op_hi", hi, 32'd0);
        check("busy_op_lo", lo, 32'd12);
        tick();
        check("no_queued_start", {31'd0, busy}, 32'd0);

        issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midreset_busy", {31'd0, busy}, 32'd0);
        check("midreset_hi", hi, 32'd0);
        check("midreset_lo", lo, 32'd0);
        for (int i = 0; i < 8; i++) tick();
        check("midreset_late_hi", hi, 32'd0);
        check("midreset_late_lo", lo, 32'd0);

        move_to(OP_MTLO, 32'hFFFF_FFFF);
        issue(OP_MADDU, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
        ncyc = 0;
        wait_idle(ncyc);
        check("maddu_cycles", ncyc, 32'd5);
        check("maddu_hi", hi, 32'd1);
        check("maddu_lo", lo, 32'd0);
`else
        check("maddu_off_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 6; i++) tick();
        check("maddu_off_hi", hi, 32'd0);
        check("maddu_off_lo", lo, 32'hFFFF_FFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
